// File: rtl/pixie_dma_host.sv
// CDP1802-side bus model for the pixie display: sequences sc, serves DMA-out from R0 and
// emulates the interrupt routine that reloads R0. Optional DMA byte counter: PIXIE_DMA_COUNT_EN.
module pixie_dma_host #(
   parameter int unsigned CYCLE_LEN  = 8,
   parameter logic [15:0] FRAME_BASE = 16'h0900,
   parameter int unsigned ISR_CYCLES = 24
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clk_enable_i,
   input  logic        dmao_i,
   input  logic        int_req_i,
   output logic [1:0]  sc_o,
   output logic [15:0] mem_addr_o,
   output logic        mem_rd_o,
   input  logic [7:0]  mem_data_i,
   output logic [7:0]  data_o,
   output logic        ie_o,
   output logic [7:0]  dma_count_o
);

   localparam int unsigned      TickW    = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;
   localparam logic [TickW-1:0] TickLast = TickW'(CYCLE_LEN - 1);
   localparam logic [TickW-1:0] TickCap  = TickW'(1);
   localparam logic [7:0]       IsrLoad  = 8'(ISR_CYCLES);

   localparam logic [1:0] ScFetch = 2'b00;
   localparam logic [1:0] ScExec  = 2'b01;
   localparam logic [1:0] ScDma   = 2'b10;
   localparam logic [1:0] ScInt   = 2'b11;

   logic [TickW-1:0] tick_q, tick_d;
   logic [1:0]       sc_q, sc_d, sc_next;
   logic [15:0]      r0_q, r0_d;
   logic [15:0]      addr_q, addr_d;
   logic             rd_q, rd_d;
   logic [7:0]       data_q, data_d;
   logic             ie_q, ie_d;
   logic [7:0]       isr_q, isr_d;
   logic             at_wrap, dma_cap, int_entry;

   assign at_wrap   = clk_enable_i && (tick_q == TickLast);
   assign dma_cap   = clk_enable_i && (sc_q == ScDma) && (tick_q == TickCap);
   assign int_entry = at_wrap && (sc_next == ScInt);

   always_comb begin
      if (dmao_i) begin
         sc_next = ScDma;
      end else if (int_req_i && ie_q) begin
         sc_next = ScInt;
      end else if (sc_q == ScFetch) begin
         sc_next = ScExec;
      end else begin
         sc_next = ScFetch;
      end
   end

   // Address/strobe and the ISR effects are registered on the wrap so they are
   // visible during tick 0 of the new cycle; RAM data then arrives for tick 1.
   always_comb begin
      tick_d = tick_q;
      sc_d   = sc_q;
      r0_d   = r0_q;
      addr_d = addr_q;
      rd_d   = rd_q;
      data_d = data_q;
      ie_d   = ie_q;
      isr_d  = isr_q;
      if (clk_enable_i) begin
         if (tick_q == '0) begin
            rd_d = 1'b0;
         end
         if (dma_cap) begin
            data_d = mem_data_i;
            r0_d   = r0_q + 16'd1;
         end
         if (at_wrap) begin
            tick_d = '0;
            sc_d   = sc_next;
            if (isr_q != 8'd0) begin
               isr_d = isr_q - 8'd1;
               if (isr_q == 8'd1) begin
                  ie_d = 1'b1;
               end
            end
            if (sc_next == ScDma) begin
               addr_d = r0_q;
               rd_d   = 1'b1;
            end
            if (int_entry) begin
               ie_d  = (IsrLoad == 8'd0);
               r0_d  = FRAME_BASE;
               isr_d = IsrLoad;
            end
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tick_q <= '0;
         sc_q   <= ScFetch;
         r0_q   <= FRAME_BASE;
         addr_q <= 16'h0000;
         rd_q   <= 1'b0;
         data_q <= 8'h00;
         ie_q   <= 1'b1;
         isr_q  <= 8'd0;
      end else begin
         tick_q <= tick_d;
         sc_q   <= sc_d;
         r0_q   <= r0_d;
         addr_q <= addr_d;
         rd_q   <= rd_d;
         data_q <= data_d;
         ie_q   <= ie_d;
         isr_q  <= isr_d;
      end
   end

`ifdef PIXIE_DMA_COUNT_EN
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (int_entry) begin
         cnt_d = 8'h00;
      end else if (dma_cap && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= 8'h00;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign dma_count_o = cnt_q;
`else
   assign dma_count_o = 8'h00;
`endif

   assign sc_o       = sc_q;
   assign mem_addr_o = addr_q;
   assign mem_rd_o   = rd_q;
   assign data_o     = data_q;
   assign ie_o       = ie_q;

endmodule

// File: tb/tb_pixie_dma_host.sv
// Directed bench for pixie_dma_host: cycle sequencing, DMA reads, ISR masking,
// priority, async reset and clock-enable freeze; a second instance covers R0 wrap.
module tb_pixie_dma_host;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_enable = 1'b1;
   logic        dmao = 1'b0;
   logic        int_req = 1'b0;
   logic [1:0]  sc;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data = 8'h00;
   logic [7:0]  data;
   logic        ie;
   logic [7:0]  dma_count;

   logic        dmao2 = 1'b0;
   logic        int_req2 = 1'b0;
   logic [1:0]  sc2;
   logic [15:0] mem_addr2;
   logic        mem_rd2;
   logic [7:0]  mem_data2 = 8'h00;
   logic [7:0]  data2;
   logic        ie2;
   logic [7:0]  dma_count2;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_cnt;

   always #5 clk = ~clk;

   pixie_dma_host dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .clk_enable_i (clk_enable),
      .dmao_i       (dmao),
      .int_req_i    (int_req),
      .sc_o         (sc),
      .mem_addr_o   (mem_addr),
      .mem_rd_o     (mem_rd),
      .mem_data_i   (mem_data),
      .data_o       (data),
      .ie_o         (ie),
      .dma_count_o  (dma_count)
   );

   pixie_dma_host #(
      .CYCLE_LEN  (4),
      .FRAME_BASE (16'hFFFF),
      .ISR_CYCLES (24)
   ) dut2 (
      .clk_i        (clk),
      .reset_i      (reset),
      .clk_enable_i (clk_enable),
      .dmao_i       (dmao2),
      .int_req_i    (int_req2),
      .sc_o         (sc2),
      .mem_addr_o   (mem_addr2),
      .mem_rd_o     (mem_rd2),
      .mem_data_i   (mem_data2),
      .data_o       (data2),
      .ie_o         (ie2),
      .dma_count_o  (dma_count2)
   );

   function automatic logic [7:0] ram(input logic [15:0] a);
      case (a)
         16'h0900: ram = 8'hA5;
         16'h0901: ram = 8'h5A;
         16'h0902: ram = 8'hFF;
         16'hFFFF: ram = 8'h3C;
         default:  ram = a[7:0] ^ 8'h11;
      endcase
   endfunction

   // Synchronous RAM: data valid the tick after the read strobe.
   always @(posedge clk) begin
      if (clk_enable && mem_rd)  mem_data  <= ram(mem_addr);
      if (clk_enable && mem_rd2) mem_data2 <= ram(mem_addr2);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
`ifdef PIXIE_DMA_COUNT_EN
      exp_cnt = 8'd3;
`else
      exp_cnt = 8'd0;
`endif
      adv(2);
      reset = 1'b0;

      // Reset state (cycle 0, tick 0)
      check_eq("rst_sc", 32'(sc), 32'h0);
      check_eq("rst_ie", 32'(ie), 32'h1);
      check_eq("rst_addr", 32'(mem_addr), 32'h0);
      check_eq("rst_data", 32'(data), 32'h0);
      check_eq("rst_cnt", 32'(dma_count), 32'h0);
      check_eq("rst_r0", 32'(dut.r0_q), 32'h0900);

      // Idle alternation over cycles 0..3
      for (int t = 0; t < 32; t++) begin
         check_eq("idle_sc", 32'(sc), ((t / 8) % 2 == 1) ? 32'h1 : 32'h0);
         check_eq("idle_rd", 32'(mem_rd), 32'h0);
         adv(1);
      end

      // Three DMA cycles (5,6,7)
      dmao = 1'b1;
      adv(8);
      for (int k = 0; k < 3; k++) begin
         check_eq("dma_sc", 32'(sc), 32'h2);
         check_eq("dma_rd_t0", 32'(mem_rd), 32'h1);
         check_eq("dma_addr", 32'(mem_addr), 32'h0900 + 32'(k));
         if (k == 2) dmao = 1'b0;
         adv(1);
         check_eq("dma_rd_t1", 32'(mem_rd), 32'h0);
         adv(1);
         check_eq("dma_data", 32'(data), (k == 0) ? 32'hA5 : (k == 1) ? 32'h5A : 32'hFF);
         adv(6);
      end
      check_eq("post_dma_sc", 32'(sc), 32'h0);
      check_eq("post_dma_r0", 32'(dut.r0_q), 32'h0903);
      check_eq("post_dma_cnt", 32'(dma_count), 32'(exp_cnt));
      adv(8);
      check_eq("alt_sc", 32'(sc), 32'h1);
      check_eq("data_hold", 32'(data), 32'hFF);

      // Clock-enable freeze at cycle 9 tick 2
      adv(2);
      check_eq("frz_tick_pre", 32'(dut.tick_q), 32'h2);
      clk_enable = 1'b0;
      adv(5);
      check_eq("frz_tick", 32'(dut.tick_q), 32'h2);
      check_eq("frz_sc", 32'(sc), 32'h1);
      check_eq("frz_r0", 32'(dut.r0_q), 32'h0903);
      check_eq("frz_data", 32'(data), 32'hFF);
      clk_enable = 1'b1;
      adv(6);
      check_eq("unfrz_sc", 32'(sc), 32'h0);

      // Interrupt at idle (cycle 11), masked for 24 cycles, then taken again
      int_req = 1'b1;
      adv(8);
      check_eq("int_sc", 32'(sc), 32'h3);
      check_eq("int_ie", 32'(ie), 32'h0);
      check_eq("int_r0", 32'(dut.r0_q), 32'h0900);
      check_eq("int_cnt", 32'(dma_count), 32'h0);
      for (int c = 0; c < 24; c++) begin
         adv(8);
         check_eq("mask_no_int", 32'(sc == 2'b11), 32'h0);
         check_eq("mask_ie", 32'(ie), (c == 23) ? 32'h1 : 32'h0);
      end
      adv(8);
      check_eq("int2_sc", 32'(sc), 32'h3);
      int_req = 1'b0;
      adv(200);
      check_eq("ie_back", 32'(ie), 32'h1);

      // DMA and INT together: DMA first, INT on first boundary after dmao falls
      dmao = 1'b1;
      int_req = 1'b1;
      adv(8);
      check_eq("both_dma1", 32'(sc), 32'h2);
      check_eq("both_addr", 32'(mem_addr), 32'h0900);
      adv(8);
      check_eq("both_dma2", 32'(sc), 32'h2);
      dmao = 1'b0;
      adv(8);
      check_eq("both_int", 32'(sc), 32'h3);
      check_eq("both_r0", 32'(dut.r0_q), 32'h0900);
      check_eq("both_cnt", 32'(dma_count), 32'h0);
      int_req = 1'b0;

      // Async reset at tick 3 of a DMA cycle
      dmao = 1'b1;
      adv(8);
      check_eq("pre_rst_sc", 32'(sc), 32'h2);
      adv(3);
      dmao = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_eq("arst_sc", 32'(sc), 32'h0);
      check_eq("arst_addr", 32'(mem_addr), 32'h0);
      check_eq("arst_rd", 32'(mem_rd), 32'h0);
      check_eq("arst_data", 32'(data), 32'h0);
      check_eq("arst_ie", 32'(ie), 32'h1);
      check_eq("arst_cnt", 32'(dma_count), 32'h0);
      check_eq("arst_r0", 32'(dut.r0_q), 32'h0900);
      adv(2);
      reset = 1'b0;
      check_eq("prst_sc0", 32'(sc), 32'h0);
      adv(8);
      check_eq("prst_sc1", 32'(sc), 32'h1);
      adv(8);
      check_eq("prst_sc2", 32'(sc), 32'h0);

      // R0 wrap on the FRAME_BASE=FFFF instance (CYCLE_LEN=4, now at cycle 4 tick 0)
      check_eq("wrap_r0_init", 32'(dut2.r0_q), 32'hFFFF);
      dmao2 = 1'b1;
      adv(4);
      check_eq("wrap_sc", 32'(sc2), 32'h2);
      check_eq("wrap_addr", 32'(mem_addr2), 32'hFFFF);
      dmao2 = 1'b0;
      adv(2);
      check_eq("wrap_data", 32'(data2), 32'h3C);
      check_eq("wrap_r0", 32'(dut2.r0_q), 32'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
